// File: rtl/dvi_capture_sched.sv
// DVI line-capture scheduler: qualifies the incoming stream, locks frame
// geometry and issues one frame-buffer write request per captured line.
module dvi_capture_sched #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned H_W    = 12,
   parameter int unsigned V_W    = 11,
   parameter int unsigned STRIDE = 4096,
   parameter bit          VS_POL = 1'b1
) (
   input  logic              odck_in,
   input  logic              rst,
   input  logic              scdt_in,
   input  logic              vsync_in,
   input  logic              de_in,
   input  logic              enable_in,
   input  logic [ADDR_W-1:0] fb_base_in,
   input  logic              line_ack_in,
   output logic              line_req_o,
   output logic [ADDR_W-1:0] line_addr_o,
   output logic [H_W-1:0]    line_len_o,
   output logic              locked_o,
   output logic [H_W-1:0]    width_o,
   output logic [V_W-1:0]    height_o,
   output logic              frame_done_o,
   output logic              overflow_o
);

   typedef enum logic [1:0] {
      ST_UNLOCKED,
      ST_MEASURE,
      ST_LOCKED,
      ST_CAPTURE
   } state_e;

   state_e state_q, state_d;

   logic vs_q, vs_d;
   logic vs_p_q, vs_p_d;
   logic de_q, de_d;
   logic de_p_q, de_p_d;

   logic [H_W-1:0] px_cnt_q, px_cnt_d;
   logic [V_W-1:0] ln_cnt_q, ln_cnt_d;
   logic [H_W-1:0] last_w_q, last_w_d;
   logic [H_W-1:0] first_w_q, first_w_d;
   logic           uni_q, uni_d;

   logic [H_W-1:0] ref_w_q, ref_w_d;
   logic [V_W-1:0] ref_h_q, ref_h_d;
   logic [H_W-1:0] width_q, width_d;
   logic [V_W-1:0] height_q, height_d;

   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] off_q, off_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [H_W-1:0]    len_q, len_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;

   logic fs;
   logic le;
   logic cap_le;
   logic lock_ok;
   logic geom_same;

   // Normalise vsync so that 1 always means "in sync pulse".
   always_comb begin
      vs_d   = vsync_in ^ ~VS_POL;
      vs_p_d = vs_q;
      de_d   = de_in;
      de_p_d = de_q;
   end

   assign fs = vs_q & ~vs_p_q;
   assign le = de_p_q & ~de_q;

   always_comb begin
      px_cnt_d  = px_cnt_q;
      ln_cnt_d  = ln_cnt_q;
      last_w_d  = last_w_q;
      first_w_d = first_w_q;
      uni_d     = uni_q;
      if (le) begin
         px_cnt_d = '0;
      end else if (de_q && (px_cnt_q != '1)) begin
         px_cnt_d = px_cnt_q + 1'b1;
      end
      if (le) begin
         last_w_d = px_cnt_q;
         if (ln_cnt_q == '0) begin
            first_w_d = px_cnt_q;
         end else if (px_cnt_q != first_w_q) begin
            uni_d = 1'b0;
         end
      end
      if (fs) begin
         ln_cnt_d = '0;
         uni_d    = 1'b1;
      end else if (le && (ln_cnt_q != '1)) begin
         ln_cnt_d = ln_cnt_q + 1'b1;
      end
   end

   // Geometry of the frame that just ended is {last_w_q, ln_cnt_q} at FS.
   assign lock_ok = (last_w_q == ref_w_q) && (ln_cnt_q == ref_h_q) &&
                    (last_w_q != '0) && (ln_cnt_q != '0) && uni_q;
   assign geom_same = (last_w_q == width_q) && (ln_cnt_q == height_q);
   assign cap_le = (state_q == ST_CAPTURE) && le;

   always_comb begin
      state_d  = state_q;
      ref_w_d  = ref_w_q;
      ref_h_d  = ref_h_q;
      width_d  = width_q;
      height_d = height_q;
      base_d   = base_q;
      off_d    = off_q;
      req_d    = req_q;
      addr_d   = addr_q;
      len_d    = len_q;
      done_d   = 1'b0;
      ovf_d    = ovf_q;

      if (req_q && line_ack_in) begin
         req_d = 1'b0;
      end
      if (cap_le) begin
         off_d = off_q + ADDR_W'(STRIDE);
         if (!req_q || line_ack_in) begin
            req_d  = 1'b1;
            addr_d = base_q + off_q;
            len_d  = px_cnt_q;
         end else begin
            ovf_d = 1'b1;
         end
      end

      unique case (state_q)
         ST_UNLOCKED: begin
            if (fs) begin
               state_d = ST_MEASURE;
               ref_w_d = '0;
               ref_h_d = '0;
            end
         end
         ST_MEASURE: begin
            if (fs) begin
               if (lock_ok) begin
                  state_d  = ST_LOCKED;
                  width_d  = last_w_q;
                  height_d = ln_cnt_q;
                  ovf_d    = 1'b0;
               end else begin
                  ref_w_d = last_w_q;
                  ref_h_d = ln_cnt_q;
               end
            end
         end
         ST_LOCKED: begin
            if (fs && enable_in) begin
               state_d = ST_CAPTURE;
               base_d  = fb_base_in;
               off_d   = '0;
            end
         end
         ST_CAPTURE: begin
            if (fs) begin
               done_d = 1'b1;
               if (!geom_same) begin
                  state_d = ST_MEASURE;
                  ref_w_d = last_w_q;
                  ref_h_d = ln_cnt_q;
               end else if (enable_in) begin
                  base_d = fb_base_in;
                  off_d  = '0;
               end else begin
                  state_d = ST_LOCKED;
               end
            end
         end
         default: state_d = ST_UNLOCKED;
      endcase

      // Loss of signal aborts everything, including an in-flight request.
      if (!scdt_in) begin
         state_d  = ST_UNLOCKED;
         req_d    = 1'b0;
         width_d  = '0;
         height_d = '0;
      end
   end

   always_ff @(posedge odck_in) begin
      if (rst) begin
         state_q   <= ST_UNLOCKED;
         vs_q      <= 1'b0;
         vs_p_q    <= 1'b0;
         de_q      <= 1'b0;
         de_p_q    <= 1'b0;
         px_cnt_q  <= '0;
         ln_cnt_q  <= '0;
         last_w_q  <= '0;
         first_w_q <= '0;
         uni_q     <= 1'b1;
         ref_w_q   <= '0;
         ref_h_q   <= '0;
         width_q   <= '0;
         height_q  <= '0;
         base_q    <= '0;
         off_q     <= '0;
         req_q     <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         done_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         vs_q      <= vs_d;
         vs_p_q    <= vs_p_d;
         de_q      <= de_d;
         de_p_q    <= de_p_d;
         px_cnt_q  <= px_cnt_d;
         ln_cnt_q  <= ln_cnt_d;
         last_w_q  <= last_w_d;
         first_w_q <= first_w_d;
         uni_q     <= uni_d;
         ref_w_q   <= ref_w_d;
         ref_h_q   <= ref_h_d;
         width_q   <= width_d;
         height_q  <= height_d;
         base_q    <= base_d;
         off_q     <= off_d;
         req_q     <= req_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         done_q    <= done_d;
         ovf_q     <= ovf_d;
      end
   end

   assign line_req_o   = req_q;
   assign line_addr_o  = addr_q;
   assign line_len_o   = len_q;
   assign locked_o     = (state_q == ST_LOCKED) || (state_q == ST_CAPTURE);
   assign width_o      = width_q;
   assign height_o     = height_q;
   assign frame_done_o = done_q;
   assign overflow_o   = ovf_q;

endmodule

// File: doc/dvi_capture_sched.md
# dvi_capture_sched

Line-capture scheduler between the DVI receiver front-end and the frame-buffer DMA writer. It qualifies the incoming stream (signal-detect plus frame-geometry lock over consecutive frames) and, while capture is enabled, issues one write request per active line. Each request carries the line's frame-buffer address and pixel count and uses a req/ack handshake. It also reports locked geometry, per-frame completion and dropped-line errors to the control plane.

## Interface
- ADDR_W, 32, byte-address width of line_addr_o
- H_W, 12, width/pixel-count width (max 4095)
- V_W, 11, line-count width (max 2047)
- STRIDE, 4096, byte distance between consecutive lines in the frame buffer
- VS_POL, 1, active level of vsync_in (1 = active high)
- odck_in  in  1  pixel clock; sole clock
- rst  in  1  synchronous, active-high reset
- scdt_in  in  1  signal-valid from receiver
- vsync_in  in  1  vertical sync
- de_in  in  1  data enable
- enable_in  in  1  capture enable (level)
- fb_base_in  in  ADDR_W  frame-buffer base, latched at capture frame start
- line_ack_in  in  1  DMA accepted current request
- line_req_o  out  1  line write request
- line_addr_o  out  ADDR_W  line start address
- line_len_o  out  H_W  pixels in line
- locked_o  out  1  geometry locked
- width_o  out  H_W  locked active width
- height_o  out  V_W  locked active height
- frame_done_o  out  1  one-cycle pulse at end of each captured frame
- overflow_o  out  1  sticky: line dropped since last reset/re-lock

## Operation
- Input stage: vsync_in (XOR ~VS_POL) and de_in are registered once. Frame start (FS) = rising edge of registered vsync. Line end (LE) = falling edge of registered de.
- Counters:
  - px_cnt counts registered-de-high cycles and clears at each LE (after use). It saturates at 2^H_W−1.
  - ln_cnt counts LEs and clears at FS. It saturates at 2^V_W−1.
  - Frame geometry = {width of last line, ln_cnt} captured at FS.
- States:
  - UNLOCKED: entered on reset or scdt_in low. On FS with scdt_in high → MEASURE; counters cleared.
  - MEASURE: at each FS compare the captured geometry with the reference. If equal, nonzero, and every line in the frame had the same width → LOCKED and set width_o/height_o. Otherwise the new geometry becomes the reference and the block stays in MEASURE. Lock therefore requires two consecutive identical frames.
  - LOCKED: locked_o=1; overflow_o cleared on entry. At FS with enable_in=1 → CAPTURE, latch fb_base_in, line_idx=0.
  - CAPTURE: each LE loads a request with line_addr_o = base + line_idx×STRIDE (mod 2^ADDR_W) and line_len_o = px_cnt, then line_idx++.
    - At each FS, pulse frame_done_o.
    - If geometry differs from width_o/height_o → MEASURE (locked_o drops). Otherwise, if enable_in=1, re-latch base, reset line_idx and stay in CAPTURE; else → LOCKED.
- Handshake:
  - line_req_o holds with stable addr/len until sampled together with line_ack_in=1. It drops on the following edge.
  - An LE while a request is pending and not acked in the same cycle drops the new line: overflow_o is set and line_idx still increments.
  - LE coincident with ack: the old request completes and the new request is loaded with no overflow.
  - A pending request at FS or on leaving CAPTURE for LOCKED/MEASURE stays held until acked.
- scdt_in low in any state → UNLOCKED on the next edge. line_req_o is deasserted immediately (request aborted), and locked_o, width_o, height_o clear.
- enable_in falling mid-frame has no effect until the next FS.

## Timing
- Reset values:
  - state UNLOCKED
  - line_req_o=0, line_addr_o=0, line_len_o=0
  - locked_o=0, width_o=0, height_o=0
  - frame_done_o=0, overflow_o=0
- If de_in is sampled high at edge k−1 and low at edge k, line_req_o and its addr/len are valid after edge k+1.
- If vsync goes active at edge k, FS effects (state change, locked_o, frame_done_o, base latch) are visible after edge k+1.
- Ack sampled at edge j → line_req_o low after edge j. At most one request outstanding.
- scdt_in low sampled at edge k → locked_o=0 and line_req_o=0 after edge k.

## Test plan
- Lock: frames of 16 px × 4 lines (hblank 8, vblank 20), scdt=1 → locked_o rises at the 3rd FS; width_o=16, height_o=4.
- Capture: locked, fb_base=0x1000_0000, enable=1, ack 2 cycles after each req → 4 requests per frame: addr 0x1000_0000, 0x1000_1000, 0x1000_2000, 0x1000_3000, len 16; frame_done_o pulses once per frame.
- Overflow: ack withheld for 30 cycles → line 1 dropped, overflow_o=1; next request addr 0x1000_2000.
- LE coincident with ack → no overflow; next request valid one cycle later.
- Geometry change: 5th line inserted while capturing → at FS frame_done pulses, locked_o=0, state MEASURE; relock after 2 matching 16×5 frames.
- scdt drop mid-line with req pending → line_req_o=0 and locked_o=0 the next cycle; no further requests until relock.
